// File: rtl/booth_seq_mul.sv
// booth_seq_mul: iterative radix-4 Booth multiplier.
// One Booth digit (two multiplier bits) is retired per clock through a single
// partial-product adder. Signed and unsigned operands; start/busy/done handshake.
//
// Handshake: start is sampled on a rising edge only while the unit is not
// retiring digits (IDLE or DONE state); operands and signed_mode are latched on
// that edge. busy is high while digits are retired, done is a one-cycle pulse
// in which result/ovf become valid; result/ovf hold until the next completion.
//
// Optional build macro BOOTH_EARLY_TERM_EN: when defined, the unit finishes as
// soon as every remaining Booth digit is known to be zero.
module booth_seq_mul #(
    parameter int WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic                 signed_mode,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    output logic                 busy,
    output logic                 done,
    output logic [2*WIDTH-1:0]   result,
    output logic                 ovf,
    output logic [1:0]           dbg_state_o
);

    // Accumulator/multiplicand width: product plus two guard bits for +/-2A.
    localparam int AW = 2 * WIDTH + 2;
    // Multiplier shift register: two extension bits, b, and the overlap bit b[-1].
    localparam int BW = WIDTH + 3;
    localparam int CW = $clog2(WIDTH / 2 + 2);
    localparam logic [CW-1:0] LAST_S = CW'(WIDTH / 2 - 1);
    localparam logic [CW-1:0] LAST_U = CW'(WIDTH / 2);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [AW-1:0]     mcand_q, mcand_d;
    logic [BW-1:0]     mult_q, mult_d;
    logic [AW-1:0]     acc_q, acc_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic              sgn_q, sgn_d;
    logic [2*WIDTH-1:0] result_q, result_d;
    logic              ovf_q, ovf_d;

    logic              accept;
    logic              finish;
    logic              last_digit;
    logic [AW-1:0]     pp;
    logic [AW-1:0]     acc_sum;
    logic [BW-1:0]     mult_shift;
    logic [WIDTH:0]    hi_signed;

    assign accept = start && (state_q != S_RUN);

    // State register; reset aborts any operation in flight.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic: a start in DONE chains straight into the next run.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (accept) state_d = S_RUN;
            S_RUN:   if (finish) state_d = S_DONE;
            S_DONE:  state_d = accept ? S_RUN : S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Output decode: busy and done come from disjoint states, so never both high.
    always_comb begin
        busy        = (state_q == S_RUN);
        done        = (state_q == S_DONE);
        dbg_state_o = state_q;
    end

    // Booth recoding of the current window {b[2i+1], b[2i], b[2i-1]}.
    always_comb begin
        pp = '0;
        case (mult_q[2:0])
            3'b001, 3'b010: pp = mcand_q;
            3'b011:         pp = {mcand_q[AW-2:0], 1'b0};
            3'b100:         pp = '0 - {mcand_q[AW-2:0], 1'b0};
            3'b101, 3'b110: pp = '0 - mcand_q;
            default:        pp = '0;
        endcase
    end

    // Partial-product add and multiplier shift; extension follows the latched mode.
    always_comb begin
        acc_sum    = acc_q + pp;
        mult_shift = {{2{sgn_q & mult_q[BW-1]}}, mult_q[BW-1:2]};
        last_digit = (cnt_q == (sgn_q ? LAST_S : LAST_U));
        hi_signed  = acc_sum[2*WIDTH-1:WIDTH-1];
    end

`ifdef BOOTH_EARLY_TERM_EN
    // Finish once the remaining bits plus overlap bit are all equal: every
    // later digit is then 000 or 111 and contributes nothing.
    always_comb begin
        finish = last_digit || (mult_shift == '0) || (sgn_q && (mult_shift == '1));
    end
`else
    // Fixed latency: finish after the last digit for the latched mode.
    always_comb begin
        finish = last_digit;
    end
`endif

    // Datapath next state: latch on accept, retire one digit per RUN cycle.
    always_comb begin
        mcand_d  = mcand_q;
        mult_d   = mult_q;
        acc_d    = acc_q;
        cnt_d    = cnt_q;
        sgn_d    = sgn_q;
        result_d = result_q;
        ovf_d    = ovf_q;
        if (accept) begin
            sgn_d   = signed_mode;
            mcand_d = {{(AW - WIDTH){signed_mode & a[WIDTH-1]}}, a};
            mult_d  = {{2{signed_mode & b[WIDTH-1]}}, b, 1'b0};
            acc_d   = '0;
            cnt_d   = '0;
        end else if (state_q == S_RUN) begin
            acc_d   = acc_sum;
            mcand_d = {mcand_q[AW-3:0], 2'b00};
            mult_d  = mult_shift;
            cnt_d   = cnt_q + CW'(1);
            if (finish) begin
                result_d = acc_sum[2*WIDTH-1:0];
                if (sgn_q) begin
                    ovf_d = !((hi_signed == '0) || (hi_signed == '1));
                end else begin
                    ovf_d = (acc_sum[2*WIDTH-1:WIDTH] != '0);
                end
            end
        end
    end

    // Datapath registers; result and ovf clear only on reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            mcand_q  <= '0;
            mult_q   <= '0;
            acc_q    <= '0;
            cnt_q    <= '0;
            sgn_q    <= 1'b0;
            result_q <= '0;
            ovf_q    <= 1'b0;
        end else begin
            mcand_q  <= mcand_d;
            mult_q   <= mult_d;
            acc_q    <= acc_d;
            cnt_q    <= cnt_d;
            sgn_q    <= sgn_d;
            result_q <= result_d;
            ovf_q    <= ovf_d;
        end
    end

    assign result = result_q;
    assign ovf    = ovf_q;

endmodule

// File: tb/tb_booth_seq_mul.sv
// Bench for booth_seq_mul (WIDTH=32): directed vectors with literal
// expectations plus a cycle-level arithmetic model checked every cycle.
module tb_booth_seq_mul;

`ifdef BOOTH_EARLY_TERM_EN
    localparam bit ET = 1'b1;
`else
    localparam bit ET = 1'b0;
`endif

    logic        clk;
    logic        rst_n;
    logic        start;
    logic        signed_mode;
    logic [31:0] a;
    logic [31:0] b;
    logic        busy;
    logic        done;
    logic [63:0] result;
    logic        ovf;
    logic [1:0]  dbg_state;

    int tests_run = 0;
    int tests_failed = 0;
    int done_cnt = 0;
    bit chk_en = 1'b0;

    booth_seq_mul #(.WIDTH(32)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .signed_mode (signed_mode),
        .a           (a),
        .b           (b),
        .busy        (busy),
        .done        (done),
        .result      (result),
        .ovf         (ovf),
        .dbg_state_o (dbg_state)
    );

    // Clock / reset
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: product by plain arithmetic, latency by the
    // "remaining multiplier bits are pure sign/zero" rule.
    function automatic logic [63:0] model_prod(input bit sgn, input logic [31:0] x, input logic [31:0] y);
        longint sp;
        if (sgn) begin
            sp = longint'($signed(x)) * longint'($signed(y));
            return 64'(sp);
        end
        return {32'b0, x} * {32'b0, y};
    endfunction

    function automatic bit model_ovf(input bit sgn, input logic [63:0] p);
        longint sp;
        sp = longint'(p);
        if (sgn) return (sp > longint'(2147483647)) || (sp < (longint'(-2147483647) - 1));
        return p[63:32] != 32'b0;
    endfunction

    function automatic int model_lat(input bit sgn, input logic [31:0] y);
        int n;
        longint s;
        n = sgn ? 16 : 17;
        if (!ET) return n;
        for (int k = 1; k < n; k++) begin
            if (sgn) begin
                s = longint'($signed(y)) >>> (2 * k - 1);
                if (s == 0 || s == -1) return k;
            end else if ((y >> (2 * k - 1)) == 32'b0) begin
                return k;
            end
        end
        return n;
    endfunction

    logic        m_busy = 1'b0;
    logic        m_done = 1'b0;
    logic [63:0] m_res = 64'b0;
    logic        m_ovf = 1'b0;
    logic [63:0] m_pend = 64'b0;
    logic        m_pend_ovf = 1'b0;
    int          m_left = 0;

    // Model advance on every rising edge.
    always @(posedge clk) begin
        if (!rst_n) begin
            m_busy = 1'b0;
            m_done = 1'b0;
            m_res  = 64'b0;
            m_ovf  = 1'b0;
            m_left = 0;
        end else if (m_busy) begin
            m_left = m_left - 1;
            if (m_left == 0) begin
                m_busy = 1'b0;
                m_done = 1'b1;
                m_res  = m_pend;
                m_ovf  = m_pend_ovf;
            end
        end else begin
            m_done = 1'b0;
            if (start) begin
                m_pend     = model_prod(signed_mode, a, b);
                m_pend_ovf = model_ovf(signed_mode, m_pend);
                m_left     = model_lat(signed_mode, b);
                m_busy     = 1'b1;
            end
        end
    end

    // Scoreboard compare on the falling edge, every cycle after reset.
    always @(negedge clk) begin
        if (chk_en) begin
            chk("busy", busy, m_busy);
            chk("done", done, m_done);
            chk("result", result, m_res);
            chk("ovf", ovf, m_ovf);
            chk("busy_and_done", busy & done, 1'b0);
            if (done) done_cnt++;
        end
    end

    // Driver: issue one operation (optionally in the current cycle) and wait for done.
    task automatic run_op(input string name, input bit sgn, input logic [31:0] x, input logic [31:0] y,
                          input logic [63:0] exp_res, input bit exp_ovf, input int exp_lat,
                          input bit no_wait);
        int cyc;
        bit got;
        if (!no_wait) begin
            @(posedge clk);
            #1;
        end
        signed_mode = sgn;
        a = x;
        b = y;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        cyc = 0;
        got = 1'b0;
        while (!got && cyc < 40) begin
            @(posedge clk);
            #1;
            cyc++;
            if (done) got = 1'b1;
        end
        chk({name, "_done_seen"}, got, 1'b1);
        chk({name, "_latency"}, cyc, exp_lat);
        chk({name, "_result"}, result, exp_res);
        chk({name, "_ovf"}, ovf, exp_ovf);
    endtask

    initial begin
        int k2;
        rst_n = 1'b0;
        start = 1'b0;
        signed_mode = 1'b0;
        a = 32'b0;
        b = 32'b0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        chk("reset_busy", busy, 1'b0);
        chk("reset_done", done, 1'b0);
        chk("reset_result", result, 64'b0);
        chk("reset_ovf", ovf, 1'b0);
        chk("reset_state", dbg_state, 2'd0);
        chk_en = 1'b1;

        run_op("neg7x3", 1'b1, 32'hFFFFFFF9, 32'd3, 64'hFFFFFFFF_FFFFFFEB, 1'b0, ET ? 2 : 16, 1'b0);
        run_op("umax_sq", 1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF, 64'hFFFFFFFE_00000001, 1'b1, 17, 1'b0);
        run_op("smin_sq", 1'b1, 32'h80000000, 32'h80000000, 64'h40000000_00000000, 1'b1, 16, 1'b0);
        run_op("zero_s", 1'b1, 32'd0, 32'd0, 64'd0, 1'b0, ET ? 1 : 16, 1'b0);
        run_op("x1234_p1", 1'b1, 32'h1234, 32'd1, 64'h1234, 1'b0, ET ? 1 : 16, 1'b0);
        run_op("x1234_m1", 1'b1, 32'h1234, 32'hFFFFFFFF, 64'hFFFFFFFF_FFFFEDCC, 1'b0, ET ? 1 : 16, 1'b0);
        run_op("smax_sq", 1'b1, 32'h7FFFFFFF, 32'h7FFFFFFF, 64'h3FFFFFFF_00000001, 1'b1, 16, 1'b0);
        run_op("m1_x_smin", 1'b1, 32'hFFFFFFFF, 32'h80000000, 64'h00000000_80000000, 1'b1, 16, 1'b0);
        run_op("smin_x_smax", 1'b1, 32'h80000000, 32'h7FFFFFFF, 64'hC0000000_80000000, 1'b1, 16, 1'b0);
        run_op("u0_x_max", 1'b0, 32'd0, 32'hFFFFFFFF, 64'd0, 1'b0, 17, 1'b0);

        // Back-to-back: second start issued in the DONE cycle of the first.
        run_op("b2b_first", 1'b0, 32'd7, 32'd8, 64'd56, 1'b0, ET ? 3 : 17, 1'b0);
        run_op("b2b_second", 1'b1, 32'hFFFFFFFD, 32'd5, 64'hFFFFFFFF_FFFFFFF1, 1'b0, ET ? 2 : 16, 1'b1);

        // Start while busy is ignored: a single done with the first product.
        k2 = ET ? 1 : 3;
        @(posedge clk);
        #1;
        signed_mode = 1'b0;
        a = 32'd5;
        b = 32'd6;
        start = 1'b1;
        @(posedge clk);
        #1;
        done_cnt = 0;
        start = 1'b0;
        for (int j = 1; j < k2; j++) begin
            @(posedge clk);
            #1;
        end
        chk("ignored_start_busy", busy, 1'b1);
        a = 32'd9;
        b = 32'd9;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (30) @(posedge clk);
        #1;
        chk("ignored_done_count", done_cnt, 1);
        chk("ignored_result", result, 64'd30);
        chk("ignored_ovf", ovf, 1'b0);

        // Reset in the middle of a run aborts without a done pulse.
        @(posedge clk);
        #1;
        signed_mode = 1'b1;
        a = 32'd1234567;
        b = 32'h07654321;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        chk("abort_busy_before", busy, 1'b1);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        done_cnt = 0;
        chk("abort_busy", busy, 1'b0);
        chk("abort_done", done, 1'b0);
        chk("abort_result", result, 64'd0);
        chk("abort_ovf", ovf, 1'b0);
        repeat (25) @(posedge clk);
        #1;
        chk("abort_no_done", done_cnt, 0);
        run_op("after_abort", 1'b1, 32'h1234, 32'd1, 64'h1234, 1'b0, ET ? 1 : 16, 1'b0);

        repeat (3) @(posedge clk);
        #1;
        chk_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
